// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (IF/MEM requesters), the single-port SRAM
// and the arbiter that shares it.
//   slave  : the arbiter's view (takes requests and SRAM read data, drives
//            ready pulses, read data, SRAM controls and busy)
//   master : the environment's view (pipeline stages plus SRAM model)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    // load/store port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    // external SRAM
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we_n;
    logic              sram_oe_n;
    // status
    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n, busy
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch (IF) and load/store
// (MEM). Each access runs IDLE -> ACCESS (SRAM_WAIT+1 cycles) -> DONE, and the
// owning port gets a one-cycle ready pulse in DONE. MEM has fixed priority
// over IF when both are waiting in IDLE.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - slave modport: IF/MEM request ports, SRAM pins, busy
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SRAM_WAIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Access latched at grant; requesters may misbehave afterwards without
    // affecting the access in flight.
    typedef struct packed {
        logic              owner_mem;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    localparam logic [3:0] LAST = 4'(SRAM_WAIT);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    acc_t              acc;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

    // ---------------- state register + datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.mem_req) begin
                        acc.owner_mem <= 1'b1;
                        acc.we        <= bus.mem_we;
                        acc.addr      <= bus.mem_addr;
                        acc.wdata     <= bus.mem_wdata;
                    end else if (bus.if_req) begin
                        // fetches leave the last write data on the pins
                        acc.owner_mem <= 1'b0;
                        acc.we        <= 1'b0;
                        acc.addr      <= bus.if_addr;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        // read data is captured at the end of the final wait
                        // state so the owner sees it in its ready cycle
                        if (!acc.we) begin
                            if (acc.owner_mem) mem_rdata_q <= bus.sram_rdata;
                            else               if_rdata_q  <= bus.sram_rdata;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // ---------------- next state + strobes ----------------
    always_comb begin
        state_nxt     = state;
        bus.sram_oe_n = 1'b1;
        bus.sram_we_n = 1'b1;
        bus.if_ready  = 1'b0;
        bus.mem_ready = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req || bus.if_req) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.sram_oe_n = acc.we;
                bus.sram_we_n = ~acc.we;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                // only one owner exists, so the two pulses are exclusive
                bus.if_ready  = ~acc.owner_mem;
                bus.mem_ready = acc.owner_mem;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.sram_addr  = acc.addr;
    assign bus.sram_wdata = acc.wdata;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.busy       = (state != IDLE);

endmodule
